branch_predictor_bht: RTL and testbench

Dynamic branch predictor combining a direct-mapped branch history table and branch target buffer (BHT/BTB). Used with the EX-stage branch resolution logic in the RV32I pipeline. IF looks up `pc_if_i` combinationally and gets a predicted next PC. EX reports each resolved instruction; the block flags mispredictions, supplies the redirect PC, trains its tables, and keeps prediction statistics.

---
 rtl/branch_predictor_bht.sv | 106 ++++++++++
 tb/tb_branch_predictor_bht.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT/BTB: combinational IF lookup, EX mispredict/redirect,
// table training on resolved control instructions, saturating statistics.
module branch_predictor_bht #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_if_i,
    output logic              pred_taken_o,
    output logic [31:0]       pred_pc_o,
    input  logic              upd_valid_i,
    input  logic              upd_ctrl_i,
    input  logic [31:0]       pc_ex_i,
    input  logic              act_taken_i,
    input  logic [31:0]       act_target_i,
    input  logic              pred_taken_ex_i,
    input  logic [31:0]       pred_pc_ex_i,
    input  logic              flush_i,
    output logic              mispredict_o,
    output logic [31:0]       redirect_pc_o,
    output logic [STAT_W-1:0] ctrl_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         cnt_q [ENTRIES];

    logic [STAT_W-1:0]  ctrl_cnt_q;
    logic [STAT_W-1:0]  mispred_cnt_q;

    logic [IDX-1:0]     if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic               if_hit;
    logic [IDX-1:0]     ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic [31:0]        correct_pc;
    logic               train;

    assign if_idx = pc_if_i[IDX+1:2];
    assign if_tag = pc_if_i[31:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign pred_taken_o = if_hit && cnt_q[if_idx][1];
    assign pred_pc_o    = pred_taken_o ? tgt_q[if_idx] : pc_if_i + 32'd4;

    assign ex_idx = pc_ex_i[IDX+1:2];
    assign ex_tag = pc_ex_i[31:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // The carried-down predicted PC alone decides a mispredict; pred_taken_ex_i
    // is implied by it and kept only for interface compatibility.
    assign correct_pc    = act_taken_i ? act_target_i : pc_ex_i + 32'd4;
    assign redirect_pc_o = correct_pc;
    assign mispredict_o  = upd_valid_i && (pred_pc_ex_i != correct_pc);

    assign train = upd_valid_i && upd_ctrl_i;

    assign ctrl_cnt_o    = ctrl_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    logic unused_pred_taken_ex;
    assign unused_pred_taken_ex = pred_taken_ex_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
        end else begin
            if (train && (ctrl_cnt_q != '1))
                ctrl_cnt_q <= ctrl_cnt_q + STAT_W'(1);
            if (mispredict_o && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);

            if (flush_i) begin
                valid_q <= '0;
            end else if (train) begin
                if (ex_hit) begin
                    if (act_taken_i) begin
                        tgt_q[ex_idx] <= act_target_i;
                        if (cnt_q[ex_idx] != 2'b11)
                            cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
                    end else if (cnt_q[ex_idx] != 2'b00) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
                    end
                end else if (act_taken_i) begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    tgt_q[ex_idx]   <= act_target_i;
                    cnt_q[ex_idx]   <= 2'b10;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_branch_predictor_bht;
    localparam int N  = 16;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   pc_if_i = '0;
    logic          pred_taken_o;
    logic [31:0]   pred_pc_o;
    logic          upd_valid_i = 1'b0;
    logic          upd_ctrl_i = 1'b0;
    logic [31:0]   pc_ex_i = '0;
    logic          act_taken_i = 1'b0;
    logic [31:0]   act_target_i = '0;
    logic          pred_taken_ex_i = 1'b0;
    logic [31:0]   pred_pc_ex_i = '0;
    logic          flush_i = 1'b0;
    logic          mispredict_o;
    logic [31:0]   redirect_pc_o;
    logic [SW-1:0] ctrl_cnt_o;
    logic [SW-1:0] mispred_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor_bht #(.ENTRIES(N), .STAT_W(SW)) dut (
        .clk_i(clk), .rst_i(rst_i), .pc_if_i(pc_if_i),
        .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
        .upd_valid_i(upd_valid_i), .upd_ctrl_i(upd_ctrl_i), .pc_ex_i(pc_ex_i),
        .act_taken_i(act_taken_i), .act_target_i(act_target_i),
        .pred_taken_ex_i(pred_taken_ex_i), .pred_pc_ex_i(pred_pc_ex_i),
        .flush_i(flush_i), .mispredict_o(mispredict_o),
        .redirect_pc_o(redirect_pc_o), .ctrl_cnt_o(ctrl_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    // Model: each slot remembers the full upper PC it belongs to, a target and
    // a confidence level 0..3 (taken predicted at 2 or more).
    bit          m_init = 1'b0;
    bit          mv   [N];
    logic [31:0] mpc  [N];
    logic [31:0] mtgt [N];
    int          mcnt [N];
    int          m_ctrl = 0;
    int          m_mis  = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[slot(pc)] && (mpc[slot(pc)] / (4 * N) == pc / (4 * N));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (mcnt[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        return m_taken(pc) ? mtgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_correct();
        return act_taken_i ? act_target_i : pc_ex_i + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return upd_valid_i && (pred_pc_ex_i != m_correct());
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_init <= 1'b1;
            m_ctrl <= 0;
            m_mis  <= 0;
            for (int i = 0; i < N; i++) begin
                mv[i] <= 1'b0; mcnt[i] <= 1; mtgt[i] <= '0; mpc[i] <= '0;
            end
        end else begin
            if (upd_valid_i && upd_ctrl_i && m_ctrl < SMAX) m_ctrl <= m_ctrl + 1;
            if (m_mispredict() && m_mis < SMAX) m_mis <= m_mis + 1;
            if (flush_i) begin
                for (int i = 0; i < N; i++) mv[i] <= 1'b0;
            end else if (upd_valid_i && upd_ctrl_i) begin
                if (m_hit(pc_ex_i)) begin
                    if (act_taken_i) begin
                        mtgt[slot(pc_ex_i)] <= act_target_i;
                        mcnt[slot(pc_ex_i)] <= (mcnt[slot(pc_ex_i)] == 3) ? 3 : mcnt[slot(pc_ex_i)] + 1;
                    end else begin
                        mcnt[slot(pc_ex_i)] <= (mcnt[slot(pc_ex_i)] == 0) ? 0 : mcnt[slot(pc_ex_i)] - 1;
                    end
                end else if (act_taken_i) begin
                    mv[slot(pc_ex_i)]   <= 1'b1;
                    mpc[slot(pc_ex_i)]  <= pc_ex_i;
                    mtgt[slot(pc_ex_i)] <= act_target_i;
                    mcnt[slot(pc_ex_i)] <= 2;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mispredict", 32'(mispredict_o), 32'(m_mispredict()));
        chk("redirect_pc", redirect_pc_o, m_correct());
        if (m_init && !rst_i) begin
            chk("pred_taken", 32'(pred_taken_o), 32'(m_taken(pc_if_i)));
            chk("pred_pc", pred_pc_o, m_pred_pc(pc_if_i));
            chk("ctrl_cnt", 32'(ctrl_cnt_o), 32'(m_ctrl));
            chk("mispred_cnt", 32'(mispred_cnt_o), 32'(m_mis));
        end
    end

    task automatic go();
        @(posedge clk); #1;
        rst_i = 1'b0; flush_i = 1'b0; upd_valid_i = 1'b0; upd_ctrl_i = 1'b0;
        act_taken_i = 1'b0; pred_taken_ex_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic upd(input logic ctrl, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic ptex, input logic [31:0] ppc);
        upd_valid_i = 1'b1; upd_ctrl_i = ctrl; pc_ex_i = pc; act_taken_i = taken;
        act_target_i = tgt; pred_taken_ex_i = ptex; pred_pc_ex_i = ppc;
    endtask

    initial begin
        // Cold state after a one-cycle reset
        go(); pc_if_i = 32'h100; settle();
        chk("lit_cold_taken", 32'(pred_taken_o), 32'd0);
        chk("lit_cold_pc", pred_pc_o, 32'h104);
        chk("lit_cold_stats", 32'({ctrl_cnt_o, mispred_cnt_o}), 32'd0);

        // Allocate 0x100 -> 0x80
        go(); upd(1, 32'h100, 1, 32'h80, 0, 32'h104); settle();
        chk("lit_alloc_mis", 32'(mispredict_o), 32'd1);
        chk("lit_alloc_redir", redirect_pc_o, 32'h80);
        chk("lit_alloc_same_cycle", 32'(pred_taken_o), 32'd0);

        // Hit; resolve not-taken in the same cycle (10 -> 01)
        go(); upd(1, 32'h100, 0, 32'h0, 1, 32'h80); settle();
        chk("lit_hit_taken", 32'(pred_taken_o), 32'd1);
        chk("lit_hit_pc", pred_pc_o, 32'h80);
        chk("lit_hit_mis_cnt", 32'(mispred_cnt_o), 32'd1);
        chk("lit_nt_redir", redirect_pc_o, 32'h104);

        go(); upd(1, 32'h100, 1, 32'h80, 0, 32'h80); settle();
        chk("lit_hyst_nt", 32'(pred_taken_o), 32'd0);
        chk("lit_hyst_nt_pc", pred_pc_o, 32'h104);
        go(); upd(1, 32'h100, 1, 32'h80, 1, 32'h80); settle();
        go(); upd(1, 32'h100, 1, 32'h80, 1, 32'h80); settle();
        go(); upd(1, 32'h100, 0, 32'h0, 1, 32'h80); settle();
        go(); settle();
        chk("lit_hyst_strong", 32'(pred_taken_o), 32'd1);
        chk("lit_hyst_ctrl", 32'(ctrl_cnt_o), 32'd6);
        chk("lit_hyst_mis", 32'(mispred_cnt_o), 32'd3);

        // Alias: same index, other tag; non-control update aliasing a taken prediction
        go(); pc_if_i = 32'h140; upd(0, 32'h100, 0, 32'h0, 1, 32'h80); settle();
        chk("lit_alias_taken", 32'(pred_taken_o), 32'd0);
        chk("lit_alias_pc", pred_pc_o, 32'h144);
        chk("lit_alias_mis", 32'(mispredict_o), 32'd1);
        chk("lit_alias_redir", redirect_pc_o, 32'h104);

        // JALR target change
        go(); pc_if_i = 32'h200; upd(1, 32'h200, 1, 32'h300, 0, 32'h204); settle();
        go(); upd(1, 32'h200, 1, 32'h400, 1, 32'h300); settle();
        chk("lit_jalr_old", pred_pc_o, 32'h300);
        chk("lit_jalr_mis", 32'(mispredict_o), 32'd1);
        chk("lit_jalr_redir", redirect_pc_o, 32'h400);
        go(); settle();
        chk("lit_jalr_new", pred_pc_o, 32'h400);
        chk("lit_jalr_ctrl", 32'(ctrl_cnt_o), 32'd8);
        chk("lit_jalr_misc", 32'(mispred_cnt_o), 32'd6);

        // Saturation of both counters
        for (int i = 0; i < 20; i++) begin
            go(); upd(1, 32'h180, 1, 32'h80, 0, 32'h0); settle();
        end
        go(); settle();
        chk("lit_sat_mis", 32'(mispred_cnt_o), 32'd15);
        chk("lit_sat_ctrl", 32'(ctrl_cnt_o), 32'd15);

        // Flush wins over a simultaneous taken update
        go(); flush_i = 1'b1; pc_if_i = 32'h100; upd(1, 32'h100, 1, 32'h80, 0, 32'h104); settle();
        go(); pc_if_i = 32'h100; settle();
        chk("lit_flush_miss", pred_pc_o, 32'h104);
        chk("lit_flush_stats", 32'(mispred_cnt_o), 32'd15);
        go(); pc_if_i = 32'h200; settle();
        chk("lit_flush_miss2", pred_pc_o, 32'h204);
        go(); pc_if_i = 32'hFFFF_FFFC; settle();
        chk("lit_wrap", pred_pc_o, 32'h0);

        // Randomized traffic, with occasional reset and flush
        go(); rst_i = 1'b1; settle();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pe;
            logic        ctl;
            logic        tk;
            int          sel;
            go();
            rst_i   = ($urandom_range(0, 299) == 0);
            flush_i = ($urandom_range(0, 99) == 0);
            pc_if_i = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                                                   : 32'h100 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 3) != 0) begin
                pe  = ($urandom_range(0, 2) == 0) ? pc_if_i : 32'h100 + 32'($urandom_range(0, 63)) * 4;
                ctl = ($urandom_range(0, 4) != 0);
                tk  = ctl && ($urandom_range(0, 2) != 0);
                upd(ctl, pe, tk, 32'h1000 + 32'($urandom_range(0, 7)) * 4, 1'b0, 32'h0);
                sel = $urandom_range(0, 2);
                pred_pc_ex_i    = (sel == 0) ? m_pred_pc(pe) : (sel == 1) ? m_correct() : $urandom;
                pred_taken_ex_i = m_taken(pe);
            end
            settle();
        end

        go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
